// File: rtl/morty_if_stage.sv
// ---------------------------------------------------------------------------
// morty_if_stage -- instruction-fetch stage of the Morty pipeline.
//
// Owns the PC and issues Wishbone-classic reads on the instruction port.
// Accepts redirects from ID (branch/jump) and from late stages (trap/xret).
// Loads the IF/ID register with pc, instruction and fetch exception.
//
// Optional feature macro: MORTY_IF_ACCESS_FAULT_EN
//   defined   : iport_err_i raises an instruction access fault (code 4'h1)
//               in IF/ID, with the faulting address in if_exc_data_o.
//   undefined : iport_err_i behaves like ack with NOP_INST as data.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_stall_i/id_bubble_i  ID hold / ID requests a NOP in IF/ID
//   take_branch_i, jump_i   ID redirects with their target addresses
//   xcpt_redirect_i         late-stage redirect (highest priority)
//   iport_*                 Wishbone-classic instruction read port
//   id_pc_o, id_instruction_o, if_exception_o, if_exc_data_o,
//   if_trap_valid_o         IF/ID register
// ---------------------------------------------------------------------------
module morty_if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_stall_i,
  input  logic        id_bubble_i,
  input  logic        take_branch_i,
  input  logic [31:0] pc_branch_address_i,
  input  logic        jump_i,
  input  logic [31:0] pc_jump_address_i,
  input  logic        xcpt_redirect_i,
  input  logic [31:0] xcpt_pc_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic [3:0]  if_exception_o,
  output logic [31:0] if_exc_data_o,
  output logic        if_trap_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ABORT = 2'd3
  } state_e;

  // What the IF/ID register takes this cycle.
  typedef enum logic [1:0] {
    LD_KEEP  = 2'd0,
    LD_NOP   = 2'd1,
    LD_FRESH = 2'd2,
    LD_HOLD  = 2'd3
  } load_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        cyc_q, cyc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        hold_trap_q, hold_trap_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [3:0]  exc_q, exc_d;
  logic [31:0] exc_data_q, exc_data_d;
  logic        trap_q, trap_d;

  logic        resp;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] fresh_inst;
  logic        fresh_trap;
  load_e       load_sel;

  // A response only counts while our own cycle is on the bus.
  assign resp = cyc_q & (iport_ack_i | iport_err_i);

  // ID redirects are suppressed by a stall; late-stage redirects never are.
  assign redirect = xcpt_redirect_i | (~id_stall_i & (jump_i | take_branch_i));
  assign target   = xcpt_redirect_i ? xcpt_pc_i :
                    jump_i          ? pc_jump_address_i : pc_branch_address_i;

  assign fresh_inst = iport_err_i ? NOP_INST : iport_data_i;
`ifdef MORTY_IF_ACCESS_FAULT_EN
  assign fresh_trap = iport_err_i;
`else
  assign fresh_trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    hold_trap_d = hold_trap_q;
    load_sel    = id_stall_i ? LD_KEEP : LD_NOP;

    if (redirect) begin
      // Flush: IF/ID gets a bubble even under stall, held word is dropped.
      pc_d     = target;
      load_sel = LD_NOP;
      state_d  = (cyc_q && !resp) ? S_ABORT : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (resp) begin
            pc_d = addr_q + 32'd4;
            if (!id_stall_i && !id_bubble_i) begin
              load_sel = LD_FRESH;
            end else begin
              // Park the word until ID can take it.
              hold_pc_d   = addr_q;
              hold_inst_d = fresh_inst;
              hold_trap_d = fresh_trap;
              state_d     = S_HOLD;
            end
          end else begin
            state_d = S_FETCH;
          end
        end
        S_HOLD: begin
          if (!id_stall_i && !id_bubble_i) begin
            load_sel = LD_HOLD;
            state_d  = S_FETCH;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_ABORT: state_d = resp ? S_FETCH : S_ABORT;
        default: state_d = S_IDLE;
      endcase
    end

    cyc_d  = (state_d == S_FETCH) || (state_d == S_ABORT);
    // The bus address stays frozen while an abandoned cycle drains.
    addr_d = (state_d == S_FETCH) ? {pc_d[31:2], 2'b00} : addr_q;
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    exc_d      = exc_q;
    exc_data_d = exc_data_q;
    trap_d     = trap_q;
    case (load_sel)
      LD_NOP: begin
        id_inst_d  = NOP_INST;
        exc_d      = 4'h0;
        exc_data_d = 32'h0;
        trap_d     = 1'b0;
      end
      LD_FRESH: begin
        id_pc_d    = addr_q;
        id_inst_d  = fresh_inst;
        exc_d      = fresh_trap ? 4'h1 : 4'h0;
        exc_data_d = fresh_trap ? addr_q : 32'h0;
        trap_d     = fresh_trap;
      end
      LD_HOLD: begin
        id_pc_d    = hold_pc_q;
        id_inst_d  = hold_inst_q;
        exc_d      = hold_trap_q ? 4'h1 : 4'h0;
        exc_data_d = hold_trap_q ? hold_pc_q : 32'h0;
        trap_d     = hold_trap_q;
      end
      default: begin
        id_pc_d = id_pc_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_ADDR;
      addr_q      <= RESET_ADDR;
      cyc_q       <= 1'b0;
      hold_pc_q   <= 32'h0;
      hold_inst_q <= NOP_INST;
      hold_trap_q <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
      exc_q       <= 4'h0;
      exc_data_q  <= 32'h0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      cyc_q       <= cyc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_trap_q <= hold_trap_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      exc_q       <= exc_d;
      exc_data_q  <= exc_data_d;
      trap_q      <= trap_d;
    end
  end

  assign iport_addr_o     = addr_q;
  assign iport_cyc_o      = cyc_q;
  assign iport_stb_o      = cyc_q;
  assign id_pc_o          = id_pc_q;
  assign id_instruction_o = id_inst_q;
  assign if_exception_o   = exc_q;
  assign if_exc_data_o    = exc_data_q;
  assign if_trap_valid_o  = trap_q;

endmodule

// File: tb/tb_morty_if_stage.sv
module tb_morty_if_stage;

  localparam logic [31:0] RST_A = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          NCYC  = 4000;

  logic        clk = 1'b0;
  logic        rst, stall, bubble, br, jmp, xr, ack, err;
  logic [31:0] bpc, jpc, xpc, data;
  logic [31:0] addr_o, id_pc, id_inst, exc_data;
  logic        cyc_o, stb_o, trap;
  logic [3:0]  exc;

  always #5 clk = ~clk;

  morty_if_stage dut (
    .clk_i(clk), .rst_i(rst),
    .id_stall_i(stall), .id_bubble_i(bubble),
    .take_branch_i(br), .pc_branch_address_i(bpc),
    .jump_i(jmp), .pc_jump_address_i(jpc),
    .xcpt_redirect_i(xr), .xcpt_pc_i(xpc),
    .iport_addr_o(addr_o), .iport_cyc_o(cyc_o), .iport_stb_o(stb_o),
    .iport_data_i(data), .iport_ack_i(ack), .iport_err_i(err),
    .id_pc_o(id_pc), .id_instruction_o(id_inst),
    .if_exception_o(exc), .if_exc_data_o(exc_data),
    .if_trap_valid_o(trap)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        trap;
  } word_t;

  word_t       held[$];      // fetched words ID has not taken yet
  logic [31:0] m_pc;         // next fetch pointer
  logic [31:0] m_addr;       // address of the outstanding bus request
  logic        m_active;     // a bus request is outstanding
  logic        m_drop;       // outstanding response belongs to a flushed fetch
  logic        m_idle;       // first cycle after reset
  logic [31:0] e_pc, e_inst, e_xd;
  logic [3:0]  e_exc;
  logic        e_trap;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic ifid_nop();
    e_inst = NOP; e_exc = 4'h0; e_xd = 32'h0; e_trap = 1'b0;
  endtask

  task automatic ifid_load(input word_t w);
    e_pc = w.pc; e_inst = w.inst; e_trap = w.trap;
    e_exc = w.trap ? 4'h1 : 4'h0;
    e_xd  = w.trap ? w.pc : 32'h0;
  endtask

  task automatic model_step();
    logic        resp, redir;
    logic [31:0] tgt;
    word_t       w;
    if (rst) begin
      held.delete();
      m_pc = RST_A; m_addr = RST_A; m_active = 1'b0; m_drop = 1'b0; m_idle = 1'b1;
      e_pc = 32'h0; ifid_nop();
      return;
    end
    resp  = m_active && (ack || err);
    redir = xr || (!stall && (jmp || br));
    tgt   = xr ? xpc : (jmp ? jpc : bpc);
    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) begin m_pc = tgt; ifid_nop(); end
      else if (!stall) ifid_nop();
      m_active = 1'b1; m_addr = align(m_pc);
      return;
    end
    if (redir) begin
      m_pc = tgt; ifid_nop(); held.delete();
      if (m_active && !resp) m_drop = 1'b1;
      else begin m_active = 1'b1; m_drop = 1'b0; m_addr = align(m_pc); end
      return;
    end
    if (resp) begin
      if (m_drop) begin
        m_drop = 1'b0; m_addr = align(m_pc);
      end else begin
        w.pc = m_addr;
        w.inst = err ? NOP : data;
`ifdef MORTY_IF_ACCESS_FAULT_EN
        w.trap = err;
`else
        w.trap = 1'b0;
`endif
        held.push_back(w);
        m_pc = m_addr + 32'd4;
      end
    end
    if (!stall) begin
      if (!bubble && held.size() > 0) begin
        w = held.pop_front();
        ifid_load(w);
      end else ifid_nop();
    end
    if (held.size() > 0) m_active = 1'b0;
    else if (!m_drop) begin m_active = 1'b1; m_addr = align(m_pc); end
  endtask

  function automatic logic [31:0] pick_target();
    int sel;
    logic [31:0] t;
    sel = $urandom_range(0, 7);
    if (sel == 0)      t = 32'hFFFF_FFFC;
    else if (sel == 1) t = 32'hFFFF_FFF8;
    else               t = RST_A + ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; br = 1'b0; jmp = 1'b0; xr = 1'b0;
    ack = 1'b0; err = 1'b0; bpc = 32'h0; jpc = 32'h0; xpc = 32'h0; data = 32'h0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("cyc", {31'h0, cyc_o}, {31'h0, m_active});
        check_eq("stb", {31'h0, stb_o}, {31'h0, m_active});
        if (m_active) check_eq("addr", addr_o, m_addr);
        check_eq("id_pc", id_pc, e_pc);
        check_eq("id_inst", id_inst, e_inst);
        check_eq("exc", {28'h0, exc}, {28'h0, e_exc});
        check_eq("exc_data", exc_data, e_xd);
        check_eq("trap", {31'h0, trap}, {31'h0, e_trap});
      end
      rst    = (i < 2) || ($urandom_range(0, 199) == 0);
      stall  = ($urandom_range(0, 99) < 25);
      bubble = ($urandom_range(0, 99) < 12);
      br     = ($urandom_range(0, 99) < 8);
      jmp    = ($urandom_range(0, 99) < 6);
      xr     = ($urandom_range(0, 99) < 3);
      bpc    = pick_target();
      jpc    = pick_target();
      xpc    = pick_target();
      ack    = ($urandom_range(0, 99) < 60);
      err    = ($urandom_range(0, 99) < 8);
      data   = $urandom;
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
